// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder and its storage bank.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int         CNT_W      = 4;
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic int be_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the load/store path and the data memory.
interface dmem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                                                  req_valid;
    logic                                                  req_ready;
    logic                                                  req_we;
    logic [31:0]                                           req_addr;
    logic [DATA_WIDTH-1:0]                                 req_wdata;
    logic [dmem_responder_pkg::be_width(DATA_WIDTH)-1:0]   req_be;
    logic                                                  rsp_valid;
    logic                                                  rsp_ready;
    logic [DATA_WIDTH-1:0]                                 rsp_rdata;
    logic                                                  rsp_err;
    logic                                                  busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/dmem_responder_bank.sv
// Word storage with byte-enabled synchronous write and registered read on one shared index.
module dmem_bank
    import dmem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            i_en,
    input  logic                            i_we,
    input  logic [ADDR_WIDTH-3:0]           i_idx,
    input  logic [be_width(DATA_WIDTH)-1:0] i_be,
    input  logic [DATA_WIDTH-1:0]           i_wdata,
    output logic [DATA_WIDTH-1:0]           o_rdata
);
    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
    localparam int BE_W  = be_width(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Read returns the pre-write word; the top only uses it for loads.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (i_be[i]) begin
                        r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
                    end
                end
            end
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_responder.sv
// Data memory target: accepts one request, waits WAIT_STATES cycles, accesses storage, then
// holds the response until the initiator takes it; misaligned/out-of-range requests return err.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);
    localparam int BE_W = be_width(DATA_WIDTH);

    state_t                  r_state;
    state_t                  w_next;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_we;
    logic [31:0]             r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [BE_W-1:0]         r_be;
    logic                    r_err;
    logic                    r_rd_sel;
    logic                    w_accept;
    logic                    w_access;
    logic                    w_err;
    logic [DATA_WIDTH-1:0]   w_bank_rdata;

    assign w_accept = (r_state == S_IDLE) && bus.req_valid;
    assign w_access = (r_state == S_WAIT) && (r_cnt == '0);
    assign w_err    = ((r_addr[1:0] & ALIGN_MASK) != 2'b00) || ((r_addr >> ADDR_WIDTH) != 32'd0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.req_valid) w_next = S_WAIT;
            S_WAIT:  if (r_cnt == '0)   w_next = S_RESP;
            S_RESP:  if (bus.rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_err    <= 1'b0;
            r_rd_sel <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= CNT_W'(WAIT_STATES);
            r_we    <= bus.req_we;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_be    <= bus.req_be;
        end else if (r_state == S_WAIT) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end else begin
                r_err    <= w_err;
                r_rd_sel <= !r_we && !w_err;
            end
        end
    end

    dmem_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
        .clk     (clk),
        .i_en    (w_access && !w_err),
        .i_we    (r_we),
        .i_idx   (r_addr[ADDR_WIDTH-1:2]),
        .i_be    (r_be),
        .i_wdata (r_wdata),
        .o_rdata (w_bank_rdata)
    );

    // Bank output is masked so stores and errors report zero data.
    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.rsp_rdata = r_rd_sel ? w_bank_rdata : '0;
    assign bus.rsp_err   = r_err;
endmodule
